// File: rtl/adpll_pkg.sv
// adpll_pkg: shared FSM encoding and default parameters for the ADPLL blocks
package adpll_pkg;
    localparam int DEF_CW         = 7;
    localparam int DEF_MW         = 10;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_TIMEOUT    = 255;
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_WAIT, S_DONE, S_ERR} coarse_state_e;
endpackage

// File: rtl/dco_wait_timer.sv
// dco_wait_timer: loadable down-counter shared by the settle and timeout waits
module dco_wait_timer #(
    parameter int TW = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          en_i,
    output logic          expired_o
);
    logic [TW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign expired_o = cnt_q == '0;
endmodule

// File: rtl/dco_coarse_ctrl.sv
// dco_coarse_ctrl: binary-search acquisition of the DCO coarse code against a target count
module dco_coarse_ctrl
    import adpll_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int MW         = DEF_MW,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [MW-1:0] fcw,
    input  logic [MW-1:0] meas,
    input  logic          meas_valid,
    output logic          meas_start,
    output logic [CW-1:0] coarse,
    output logic          busy,
    output logic          lock,
    output logic          err
);
    localparam int TMAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(CW);
    localparam logic [CW-1:0] MID    = {1'b1, {(CW-1){1'b0}}};
    localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT - 1);

    coarse_state_e state_q, state_d;
    logic [CW-1:0] coarse_q, coarse_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          meas_start_q, meas_start_d;
    logic          tmr_load, tmr_exp;
    logic [TW-1:0] tmr_val;

    dco_wait_timer #(.TW(TW)) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (busy),
        .expired_o  (tmr_exp)
    );

    always_comb begin
        state_d      = state_q;
        coarse_d     = coarse_q;
        idx_d        = idx_q;
        meas_start_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = SET_LD;
        case (state_q)
            S_SETTLE: if (tmr_exp) begin
                state_d      = S_WAIT;
                meas_start_d = 1'b1;
                tmr_load     = 1'b1;
                tmr_val      = TO_LD;
            end
            // a measurement arriving on the timeout cycle still counts
            S_WAIT: if (meas_valid) begin
                if (meas > fcw) coarse_d[idx_q] = 1'b0;
                if (idx_q == '0) state_d = S_DONE;
                else begin
                    coarse_d[idx_q - 1'b1] = 1'b1;
                    idx_d    = idx_q - 1'b1;
                    state_d  = S_SETTLE;
                    tmr_load = 1'b1;
                end
            end else if (tmr_exp) state_d = S_ERR;
            default: if (start) begin
                state_d  = S_SETTLE;
                coarse_d = MID;
                idx_d    = IW'(CW - 1);
                tmr_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            coarse_q     <= MID;
            idx_q        <= '0;
            meas_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            coarse_q     <= coarse_d;
            idx_q        <= idx_d;
            meas_start_q <= meas_start_d;
        end
    end

    assign coarse     = coarse_q;
    assign meas_start = meas_start_q;
    assign busy       = state_q == S_SETTLE || state_q == S_WAIT;
    assign lock       = state_q == S_DONE;
    assign err        = state_q == S_ERR;
endmodule

// File: tb/tb_dco_coarse_ctrl.sv
// tb_dco_coarse_ctrl: scoreboard bench with a counter model meas = 4*coarse + 100, 3 cycles latency
module tb_dco_coarse_ctrl;
    typedef int code_t [7];
    typedef struct {
        logic lk;
        logic er;
        int   code;
        int   dcyc;
        int   np;
    } fin_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] fcw = '0;
    logic [9:0] meas;
    logic       meas_valid;
    logic       meas_start;
    logic [6:0] coarse;
    logic       busy, lock, err;

    logic [2:0] mdl_pipe = '0;
    logic       mdl_en = 1'b1;
    logic       stray_v = 1'b0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         code_q[$];
    fin_t       fin_q[$];
    int         t0 = 0;
    int         np = 0;
    logic       lock_prev = 1'b0;
    logic       err_prev = 1'b0;
    logic       busy_prev = 1'b0;
    int         exp_code;
    fin_t       ef;

    code_t c300  = '{64, 32, 48, 56, 52, 50, 51};
    code_t c99   = '{64, 32, 16, 8, 4, 2, 1};
    code_t c1023 = '{64, 96, 112, 120, 124, 126, 127};
    code_t c356  = '{64, 96, 80, 72, 68, 66, 65};
    code_t c_to  = '{64, 0, 0, 0, 0, 0, 0};

    dco_coarse_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fcw        (fcw),
        .meas       (meas),
        .meas_valid (meas_valid),
        .meas_start (meas_start),
        .coarse     (coarse),
        .busy       (busy),
        .lock       (lock),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mdl_pipe <= {mdl_pipe[1:0], meas_start && mdl_en};
    end
    assign meas_valid = mdl_pipe[2] | stray_v;
    assign meas       = mdl_pipe[2] ? ({1'b0, coarse, 2'b00} + 10'd100) : '0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            t0 = cyc;
            np = 0;
        end
        if (meas_start) begin
            np++;
            if (code_q.size() == 0) chk("unexpected_meas_start", 1, 0);
            else begin
                exp_code = code_q.pop_front();
                chk("meas_start_code", int'(coarse), exp_code);
            end
        end
        if ((lock && !lock_prev) || (err && !err_prev)) begin
            if (fin_q.size() == 0) chk("unexpected_finish", 1, 0);
            else begin
                ef = fin_q.pop_front();
                chk("final_lock", int'(lock), int'(ef.lk));
                chk("final_err", int'(err), int'(ef.er));
                chk("final_coarse", int'(coarse), ef.code);
                chk("final_busy", int'(busy), 0);
                chk("search_cycles", cyc - t0, ef.dcyc);
                chk("meas_start_count", np, ef.np);
            end
        end
        if (lock && err) chk("lock_err_exclusive", 1, 0);
        lock_prev = lock;
        err_prev  = err;
        busy_prev = busy;
    end

    task automatic expect_run(input int f, input code_t c, input int n, input int fin_code,
                              input logic lk, input int dcyc, input logic push_fin);
        fcw = 10'(f);
        for (int k = 0; k < n; k++) code_q.push_back(c[k]);
        if (push_fin) fin_q.push_back('{lk, !lk, fin_code, dcyc, n});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && busy; k++) @(negedge clk);
        if (busy) chk("wait_idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_coarse", int'(coarse), 64);
        chk("reset_busy", int'(busy), 0);
        chk("reset_lock", int'(lock), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_meas_start", int'(meas_start), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        expect_run(300, c300, 7, 50, 1'b1, 56, 1'b1);
        pulse_start();
        wait_idle(200);
        expect_run(99, c99, 7, 0, 1'b1, 56, 1'b1);
        pulse_start();
        wait_idle(200);
        expect_run(1023, c1023, 7, 127, 1'b1, 56, 1'b1);
        pulse_start();
        wait_idle(200);
        expect_run(356, c356, 7, 64, 1'b1, 56, 1'b1);
        pulse_start();
        wait_idle(200);

        mdl_en = 1'b0;
        expect_run(300, c_to, 1, 64, 1'b0, 259, 1'b1);
        pulse_start();
        wait_idle(600);
        mdl_en = 1'b1;
        expect_run(300, c300, 7, 50, 1'b1, 56, 1'b1);
        pulse_start();
        wait_idle(200);

        expect_run(300, c300, 7, 50, 1'b1, 56, 1'b1);
        pulse_start();
        @(negedge clk);
        stray_v = 1'b1;
        @(negedge clk);
        stray_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (7) @(negedge clk);
            pulse_start();
        end
        wait_idle(200);

        expect_run(300, c300, 3, 0, 1'b0, 0, 1'b0);
        pulse_start();
        repeat (21) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_coarse", int'(coarse), 64);
        chk("abort_busy", int'(busy), 0);
        chk("abort_meas_start", int'(meas_start), 0);
        chk("abort_lock", int'(lock), 0);
        repeat (12) @(negedge clk);
        expect_run(300, c300, 7, 50, 1'b1, 56, 1'b1);
        pulse_start();
        wait_idle(200);

        chk("codes_left", code_q.size(), 0);
        chk("finals_left", fin_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
